// File: rtl/ecc_dec_pipe.sv
// ecc_dec_pipe: two-stage extended-Hamming decoder
// with valid/ready flow control and error stats.
module ecc_dec_pipe #(
  parameter int MAX_CODEWORD_WIDTH = 32,
  parameter int MAX_PARITY_WIDTH   = 6,
  parameter int CNT_WIDTH          = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [MAX_CODEWORD_WIDTH-1:0] data_in,
  input  logic [1:0]                    work_mod,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [MAX_CODEWORD_WIDTH-1:0] data_out,
  output logic [1:0]                    num_of_errors,
  output logic [MAX_PARITY_WIDTH-1:0]   syndrome_out,
  input  logic                          cnt_clear,
  output logic [CNT_WIDTH-1:0]          corr_cnt,
  output logic [CNT_WIDTH-1:0]          uncorr_cnt
);

  localparam int W = MAX_CODEWORD_WIDTH;
  localparam int P = MAX_PARITY_WIDTH;

  localparam logic [47:0]  H8  = 48'hFFE4_D2B1;
  localparam logic [95:0]  H16 =
    96'hFFFF_FE08_F1C4_CDA2_AB61;
  localparam logic [191:0] H32 =
    192'hFFFF_FFFF_FFFE_0010_FF01_FC08_F0F1_E384_CCCD_9B42_AAAB_56C1;

  logic         s1_valid;
  logic [W-1:0] s1_data;
  logic [1:0]   s1_mod;
  logic [P-1:0] s1_syn;

  logic         s2_adv;
  logic [P-1:0] in_syn;
  logic [W-1:0] corr;
  logic [W-1:0] mask;
  logic [P-1:0] col;
  logic [1:0]   num_nxt;
  logic         out_hs;

  assign s2_adv   = !out_valid || out_ready;
  assign in_ready = !s1_valid || s2_adv;
  assign out_hs   = out_valid && out_ready;

  // Syndrome of the incoming word in its own mode
  always_comb begin
    in_syn = '0;
    unique case (work_mod)
      2'b00:
        for (int i = 0; i < 8; i++)
          for (int r = 0; r < P; r++)
            in_syn[r] = in_syn[r] ^
              (H8[r*8+i] & data_in[i]);
      2'b01:
        for (int i = 0; i < 16; i++)
          for (int r = 0; r < P; r++)
            in_syn[r] = in_syn[r] ^
              (H16[r*16+i] & data_in[i]);
      2'b10:
        for (int i = 0; i < 32; i++)
          for (int r = 0; r < P; r++)
            in_syn[r] = in_syn[r] ^
              (H32[r*32+i] & data_in[i]);
      default: in_syn = '0;
    endcase
  end

  // Correction vector: flip every column matching s
  always_comb begin
    corr = '0;
    mask = '0;
    col  = '0;
    unique case (s1_mod)
      2'b00:
        for (int i = 0; i < 8; i++) begin
          mask[i] = 1'b1;
          for (int r = 0; r < P; r++)
            col[r] = H8[r*8+i];
          corr[i] = (col == s1_syn);
        end
      2'b01:
        for (int i = 0; i < 16; i++) begin
          mask[i] = 1'b1;
          for (int r = 0; r < P; r++)
            col[r] = H16[r*16+i];
          corr[i] = (col == s1_syn);
        end
      2'b10:
        for (int i = 0; i < 32; i++) begin
          mask[i] = 1'b1;
          for (int r = 0; r < P; r++)
            col[r] = H32[r*32+i];
          corr[i] = (col == s1_syn);
        end
      default: mask = '1;
    endcase
  end

  // Error class: clean, corrected, uncorrectable
  always_comb begin
    num_nxt = 2'b10;
    unique case (1'b1)
      (s1_syn == '0): num_nxt = 2'b00;
      (|corr):        num_nxt = 2'b01;
      default:        num_nxt = 2'b10;
    endcase
  end

  // Stage 1: capture word, mode and syndrome
  always_ff @(posedge clk) begin
    if (!rst) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
      s1_mod   <= '0;
      s1_syn   <= '0;
    end else if (in_ready) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_data <= data_in;
        s1_mod  <= work_mod;
        s1_syn  <= in_syn;
      end
    end
  end

  // Stage 2: corrected word, held while stalled
  always_ff @(posedge clk) begin
    if (!rst) begin
      out_valid     <= 1'b0;
      data_out      <= '0;
      num_of_errors <= 2'b00;
      syndrome_out  <= '0;
    end else if (s2_adv) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        data_out      <= (s1_data & mask) ^ corr;
        num_of_errors <= num_nxt;
        syndrome_out  <= s1_syn;
      end
    end
  end

  // Saturating corrected-word counter
  always_ff @(posedge clk) begin
    if (!rst || cnt_clear)
      corr_cnt <= '0;
    else if (out_hs && num_of_errors == 2'b01
             && corr_cnt != '1)
      corr_cnt <= corr_cnt + CNT_WIDTH'(1);
  end

  // Saturating uncorrectable-word counter
  always_ff @(posedge clk) begin
    if (!rst || cnt_clear)
      uncorr_cnt <= '0;
    else if (out_hs && num_of_errors == 2'b10
             && uncorr_cnt != '1)
      uncorr_cnt <= uncorr_cnt + CNT_WIDTH'(1);
  end

endmodule
